// File: rtl/pipeline_run_ctrl.sv
// Run/halt sequencer for the 5-stage pipeline: boot hold, HALT/debug halts,
// drain, single-step, plus cycle and retire counters.
module pipeline_run_ctrl #(
  parameter int BOOT_CYCLES  = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_instr,
  input  logic             dbg_halt_req,
  input  logic             dbg_resume_req,
  input  logic             dbg_step_req,
  input  logic             retire,
  output logic             pipe_halt,
  output logic             id_bubble,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic             step_done,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_HALTED = 3'd3,
    S_STEP   = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_DBG   = 2'd1;
  localparam logic [1:0] CAUSE_INSTR = 2'd2;

  // Boot and drain never overlap, so one down-counter serves both.
  localparam int TMAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] BOOT_LD  = TW'(BOOT_CYCLES - 1);
  localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN_CYCLES - 1);

  state_t          st;
  logic [TW-1:0]   tmr;
  logic [1:0]      cause_q;
  logic            halted_q;
  logic            step_done_q;
  logic            from_step;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ret_q;

  // Only RUN and STEP let IF/ID advance, and a decoded HALT freezes them at once.
  always_comb begin
    pipe_halt = 1'b1;
    if (st == S_RUN || st == S_STEP) pipe_halt = halt_instr;
  end

  assign id_bubble  = pipe_halt;
  assign halted     = halted_q;
  assign halt_cause = cause_q;
  assign step_done  = step_done_q;
  assign state      = st;
  assign cycle_cnt  = cyc_q;
  assign retire_cnt = ret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_BOOT;
      tmr         <= BOOT_LD;
      cause_q     <= CAUSE_NONE;
      halted_q    <= 1'b0;
      step_done_q <= 1'b0;
      from_step   <= 1'b0;
      cyc_q       <= '0;
      ret_q       <= '0;
    end else begin
      step_done_q <= 1'b0;
      if (!pipe_halt) cyc_q <= cyc_q + CNT_W'(1);
      if (retire)     ret_q <= ret_q + CNT_W'(1);

      case (st)
        S_BOOT: begin
          if (tmr == '0) st <= S_RUN;
          else           tmr <= tmr - TW'(1);
        end
        S_RUN: begin
          if (halt_instr) begin
            st        <= S_DRAIN;
            tmr       <= DRAIN_LD;
            cause_q   <= CAUSE_INSTR;
            from_step <= 1'b0;
          end else if (dbg_halt_req) begin
            st        <= S_DRAIN;
            tmr       <= DRAIN_LD;
            cause_q   <= CAUSE_DBG;
            from_step <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (tmr == '0) begin
            st          <= S_HALTED;
            halted_q    <= 1'b1;
            step_done_q <= from_step;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_HALTED: begin
          // An instruction halt is terminal; only reset leaves it.
          if (cause_q == CAUSE_DBG) begin
            if (dbg_step_req) begin
              st       <= S_STEP;
              halted_q <= 1'b0;
            end else if (dbg_resume_req) begin
              st       <= S_RUN;
              halted_q <= 1'b0;
              cause_q  <= CAUSE_NONE;
            end
          end
        end
        S_STEP: begin
          st  <= S_DRAIN;
          tmr <= DRAIN_LD;
          if (halt_instr) begin
            cause_q   <= CAUSE_INSTR;
            from_step <= 1'b0;
          end else begin
            from_step <= 1'b1;
          end
        end
        default: begin
          st  <= S_BOOT;
          tmr <= BOOT_LD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed vector table, hand-written corner
// sequences, then random stimulus against a time-in-mode reference model.
module tb_pipeline_run_ctrl;

  localparam int BOOT_N  = 4;
  localparam int DRAIN_N = 3;
  localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3, M_STEP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, halt_instr = 1'b0, dbg_halt_req = 1'b0;
  logic dbg_resume_req = 1'b0, dbg_step_req = 1'b0, retire = 1'b0;

  logic        pipe_halt, id_bubble, halted, step_done;
  logic [1:0]  halt_cause;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, retire_cnt;

  logic        ph4, bub4, hlt4, sd4;
  logic [1:0]  cause4;
  logic [2:0]  st4;
  logic [3:0]  cc4, rc4;

  pipeline_run_ctrl #(.BOOT_CYCLES(BOOT_N), .DRAIN_CYCLES(DRAIN_N), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .halt_instr(halt_instr), .dbg_halt_req(dbg_halt_req),
    .dbg_resume_req(dbg_resume_req), .dbg_step_req(dbg_step_req), .retire(retire),
    .pipe_halt(pipe_halt), .id_bubble(id_bubble), .halted(halted),
    .halt_cause(halt_cause), .step_done(step_done), .state(state),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt));

  pipeline_run_ctrl #(.BOOT_CYCLES(BOOT_N), .DRAIN_CYCLES(DRAIN_N), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .halt_instr(halt_instr), .dbg_halt_req(dbg_halt_req),
    .dbg_resume_req(dbg_resume_req), .dbg_step_req(dbg_step_req), .retire(retire),
    .pipe_halt(ph4), .id_bubble(bub4), .halted(hlt4),
    .halt_cause(cause4), .step_done(sd4), .state(st4),
    .cycle_cnt(cc4), .retire_cnt(rc4));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode plus cycles spent in it; transitions from the rules.
  int          m_mode = M_BOOT, m_t = 0, m_cause = 0;
  bit          m_fs = 0, m_sd = 0, started = 0, model_on = 0;
  logic [31:0] m_cyc = '0, m_ret = '0;

  function automatic bit m_ph();
    return (m_mode == M_RUN || m_mode == M_STEP) ? halt_instr : 1'b1;
  endfunction

  task automatic m_advance();
    int nxt;
    bit ph;
    ph = m_ph();
    if (reset) begin
      m_mode = M_BOOT; m_t = 0; m_cause = 0; m_fs = 0; m_sd = 0;
      m_cyc = '0; m_ret = '0;
      return;
    end
    if (!ph) m_cyc = m_cyc + 32'd1;
    if (retire) m_ret = m_ret + 32'd1;
    m_sd = 0;
    nxt  = m_mode;
    case (m_mode)
      M_BOOT:  if (m_t + 1 >= BOOT_N) nxt = M_RUN;
      M_RUN: begin
        if (halt_instr) begin nxt = M_DRAIN; m_cause = 2; m_fs = 0; end
        else if (dbg_halt_req) begin nxt = M_DRAIN; m_cause = 1; m_fs = 0; end
      end
      M_DRAIN: if (m_t + 1 >= DRAIN_N) begin nxt = M_HALTED; m_sd = m_fs; end
      M_HALTED: begin
        if (m_cause == 1) begin
          if (dbg_step_req) nxt = M_STEP;
          else if (dbg_resume_req) begin nxt = M_RUN; m_cause = 0; end
        end
      end
      M_STEP: begin
        nxt = M_DRAIN;
        if (halt_instr) begin m_cause = 2; m_fs = 0; end
        else m_fs = 1;
      end
      default: nxt = M_BOOT;
    endcase
    m_t    = (nxt == m_mode) ? m_t + 1 : 0;
    m_mode = nxt;
  endtask

  task automatic m_compare();
    logic [31:0] mc;
    mc = m_cyc;
    chk("rnd_pipe_halt", pipe_halt, m_ph());
    chk("rnd_id_bubble", id_bubble, m_ph());
    chk("rnd_halted", halted, m_mode == M_HALTED);
    chk("rnd_cause", halt_cause, m_cause);
    chk("rnd_step_done", step_done, m_sd);
    chk("rnd_state", state, m_mode);
    chk("rnd_cycle_cnt", cycle_cnt, m_cyc);
    chk("rnd_retire_cnt", retire_cnt, m_ret);
    chk("rnd_cycle_cnt4", cc4, mc[3:0]);
  endtask

  // One clock: advance model over the edge just ahead, drive new inputs at negedge.
  task automatic tick(input bit r, input bit hi, input bit dh, input bit dr,
                      input bit ds, input bit ret);
    if (started) m_advance();
    started = 1;
    @(negedge clk);
    reset = r; halt_instr = hi; dbg_halt_req = dh;
    dbg_resume_req = dr; dbg_step_req = ds; retire = ret;
    #1;
    if (model_on) m_compare();
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0);
  endtask

  // Leaves the DUT so that the next tick is post-reset cycle 4 (first RUN cycle).
  task automatic do_reset();
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    repeat (BOOT_N) idle();
  endtask

  typedef struct {
    bit chk_en;
    bit r, hi, dh, dr, ds, ret;
    bit ph, hlt;
    logic [1:0] cause;
    bit sd;
    logic [2:0] st;
    int cc, rc;
  } vec_t;

  vec_t tbl[14];
  logic [31:0] cc_s, rc_s;

  initial begin
    // chk r hi dh dr ds ret | ph hlt cause sd st cc rc
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0}; // cycle 0
    tbl[3]  = '{1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0}; // debug ignored in boot
    tbl[4]  = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0}; // cycle 3
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0}; // cycle 4: first fetch
    tbl[7]  = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1}; // HALT + debug together
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 2, 1, 2};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 2, 1, 3};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 2, 1, 3};
    tbl[11] = '{1, 0, 0, 0, 1, 1, 0, 1, 1, 2, 0, 3, 1, 3}; // halted at 5+1+3
    tbl[12] = '{1, 0, 0, 0, 1, 0, 0, 1, 1, 2, 0, 3, 1, 3}; // resume ignored
    tbl[13] = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 3, 1, 3};

    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].r, tbl[i].hi, tbl[i].dh, tbl[i].dr, tbl[i].ds, tbl[i].ret);
      if (tbl[i].chk_en) begin
        chk($sformatf("vec%0d_pipe_halt", i), pipe_halt, tbl[i].ph);
        chk($sformatf("vec%0d_id_bubble", i), id_bubble, tbl[i].ph);
        chk($sformatf("vec%0d_halted", i), halted, tbl[i].hlt);
        chk($sformatf("vec%0d_cause", i), halt_cause, tbl[i].cause);
        chk($sformatf("vec%0d_step_done", i), step_done, tbl[i].sd);
        chk($sformatf("vec%0d_state", i), state, tbl[i].st);
        chk($sformatf("vec%0d_cycle_cnt", i), cycle_cnt, tbl[i].cc);
        chk($sformatf("vec%0d_retire_cnt", i), retire_cnt, tbl[i].rc);
      end
    end

    // Debug halt at 10, resume at 16.
    do_reset();
    repeat (6) idle();
    tick(0, 0, 1, 0, 0, 0);
    chk("dbg_halt_no_comb", pipe_halt, 0);
    idle(); chk("dbg_drain_entry", state, M_DRAIN);
    idle(); idle(); chk("dbg_not_yet_halted", halted, 0);
    idle(); chk("dbg_halted", halted, 1); chk("dbg_cause", halt_cause, 1);
    idle();
    tick(0, 0, 0, 1, 0, 0);
    idle();
    chk("resume_state", state, M_RUN); chk("resume_cause", halt_cause, 0);
    chk("resume_halted", halted, 0);
    cc_s = cycle_cnt;
    idle(); chk("resume_counting", cycle_cnt, cc_s + 32'd1);

    // Single step: halt at 19, step pulse at 23, step_done at 28.
    tick(0, 0, 1, 0, 0, 0);
    repeat (3) idle();
    tick(0, 0, 0, 0, 1, 0);
    chk("step_pre_halted", halted, 1);
    rc_s = retire_cnt; cc_s = cycle_cnt;
    idle(); chk("step_issue", pipe_halt, 0); chk("step_state", state, M_STEP);
    idle(); chk("step_refreeze", pipe_halt, 1); chk("step_drain", state, M_DRAIN);
    tick(0, 0, 0, 0, 0, 1);
    idle();
    idle();
    chk("step_done_pulse", step_done, 1); chk("step_halted", halted, 1);
    chk("step_retire", retire_cnt, rc_s + 32'd1); chk("step_cycles", cycle_cnt, cc_s + 32'd1);

    // Step and resume together -> STEP; then HALT in STEP -> cause 2, no step_done.
    tick(0, 0, 0, 1, 1, 0);
    chk("step_done_one_cycle", step_done, 0);
    tick(0, 1, 0, 0, 0, 0);
    chk("step_wins", state, M_STEP); chk("step_halt_instr_freeze", pipe_halt, 1);
    chk("step_halt_instr_bubble", id_bubble, 1);
    idle(); chk("step_halt_cause", halt_cause, 2); chk("step_halt_drain", state, M_DRAIN);
    idle(); idle(); idle();
    chk("step_halt_halted", state, M_HALTED); chk("step_halt_no_done", step_done, 0);

    // Reset in the second drain cycle.
    do_reset();
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 0, 0);
    idle(); chk("middrain_cause_before", halt_cause, 1);
    tick(1, 0, 0, 0, 0, 0);
    idle();
    chk("middrain_state", state, M_BOOT); chk("middrain_cause", halt_cause, 0);
    chk("middrain_cycle_cnt", cycle_cnt, 0); chk("middrain_retire_cnt", retire_cnt, 0);
    chk("middrain_pipe_halt", pipe_halt, 1);

    // Counter wrap on the 4-bit instance.
    do_reset();
    repeat (15) idle();
    idle(); chk("wrap_cc4_15", cc4, 4'd15);
    idle(); chk("wrap_cc4_0", cc4, 4'd0); chk("wrap_cc32_16", cycle_cnt, 16);

    // Random phase against the model.
    do_reset();
    model_on = 1;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end
    model_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Run/halt sequencer for the 5-stage RISC-V pipeline. It drives the datapath's `Halt` input plus an ID/EX bubble request, and decides when the core fetches. It handles:
- the post-reset boot hold;
- halts from the HALT instruction and from the debug port;
- pipeline drain;
- single-step;
- cycle and retired-instruction counters for the testbench.

## Interface
Parameters:
- `BOOT_CYCLES`, default 4: cycles the pipeline is held after reset.
- `DRAIN_CYCLES`, default 3: bubble cycles needed to empty ID/EX, EX/MEM and MEM/WB.
- `CNT_W`, default 32: width of the cycle and retire counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `halt_instr`  in  1  HALT opcode decoded in ID (IF/ID holds a valid HALT).
- `dbg_halt_req`  in  1  single-cycle debug halt pulse.
- `dbg_resume_req`  in  1  single-cycle debug resume pulse.
- `dbg_step_req`  in  1  single-cycle debug single-step pulse.
- `retire`  in  1  WB stage holds a non-bubble instruction this cycle.
- `pipe_halt`  out  1  to datapath `Halt`: freezes PC and IF/ID.
- `id_bubble`  out  1  forces ID/EX to load a NOP, same effect as a hazard stall.
- `halted`  out  1  pipeline fully drained and stopped.
- `halt_cause`  out  2  0 = none, 1 = debug, 2 = instruction.
- `step_done`  out  1  one-cycle pulse when a single-step completes.
- `state`  out  3  current FSM state, for debug.
- `cycle_cnt`  out  CNT_W  active (fetching) cycles.
- `retire_cnt`  out  CNT_W  retired instructions.

## Operation
State encoding: BOOT = 0, RUN = 1, DRAIN = 2, HALTED = 3, STEP = 4.

Per-state behaviour:
- **BOOT**
  - `pipe_halt` = 1, `id_bubble` = 1.
  - A down-counter loads `BOOT_CYCLES - 1` on reset; the FSM moves to RUN when it reaches 0.
  - Debug requests are ignored.
- **RUN**
  - `pipe_halt` = `halt_instr`, `id_bubble` = `halt_instr` (combinational). The HALT instruction never enters EX and PC does not advance past it.
  - On `halt_instr`: go to DRAIN with cause = 2.
  - Else on `dbg_halt_req`: go to DRAIN with cause = 1.
  - `halt_instr` has priority when both are present.
- **DRAIN**
  - `pipe_halt` = 1, `id_bubble` = 1.
  - The drain counter loads `DRAIN_CYCLES - 1` on entry; the FSM moves to HALTED when it reaches 0.
  - If entered from STEP, `step_done` pulses in the cycle HALTED is first entered.
  - Debug requests are ignored.
- **HALTED**
  - `pipe_halt` = 1, `id_bubble` = 1, `halted` = 1.
  - If cause = 2, the state is terminal: resume and step are ignored until reset.
  - If cause = 1:
    - `dbg_step_req` goes to STEP.
    - Else `dbg_resume_req` goes to RUN and clears cause to 0.
    - Step wins when both arrive in the same cycle.
- **STEP**
  - Lasts exactly one cycle with `pipe_halt` = 0 and `id_bubble` = 0, so exactly one instruction issues from IF/ID to EX.
  - Then goes to DRAIN, cause stays 1.
  - If `halt_instr` is high in this cycle: `pipe_halt`/`id_bubble` = 1, cause = 2, go to DRAIN, and no `step_done` is issued.

Counters:
- `cycle_cnt` increments in cycles where `pipe_halt` = 0 (RUN or STEP).
- `retire_cnt` increments on `retire` in any state, including DRAIN.
- Both wrap modulo 2^CNT_W without flag.

## Timing
- Reset values (held while `reset` = 1 and in the first cycle after):
  - state = BOOT, `pipe_halt` = 1, `id_bubble` = 1, `halted` = 0, `halt_cause` = 0, `step_done` = 0.
  - Both counters = 0; boot counter = `BOOT_CYCLES - 1`.
- First fetch cycle is cycle `BOOT_CYCLES` after reset deasserts, counting the first post-reset cycle as 0.
- `pipe_halt` and `id_bubble` are combinational from the state register and `halt_instr`, with zero-cycle response; there is no path from the debug inputs.
- `halted`, `halt_cause`, `step_done` and `state` are registered (Moore).
- Halt latency:
  - debug halt pulse in cycle n: DRAIN from n+1, `halted` at n+1+`DRAIN_CYCLES`;
  - `halt_instr` in cycle n: the same.
- Step: pulse at n, STEP at n+1, DRAIN n+2 .. n+1+`DRAIN_CYCLES`, `step_done` and `halted` at n+2+`DRAIN_CYCLES`.
- Reset mid-operation, in any state or mid-drain: next cycle is BOOT, counters cleared, cause cleared.
- `DRAIN_CYCLES` and `BOOT_CYCLES` must be ≥ 1; a value of 1 means a single-cycle stay.

## Test plan
- **Reset/boot:** release reset at cycle 0 → `pipe_halt` = 1 for cycles 0–3, RUN at cycle 4; `cycle_cnt` = 1 at cycle 5.
- **HALT instruction:** `halt_instr` = 1 at cycle 20 in RUN → `pipe_halt`/`id_bubble` = 1 in cycle 20, `halted` = 1 at 24, `halt_cause` = 2. A later `dbg_resume_req` keeps `halted` = 1.
- **Debug halt/resume:** `dbg_halt_req` at 10 → `halted` at 14, cause = 1. Resume at 16 → state RUN at 17, `cycle_cnt` increments again, cause = 0.
- **Single step:** with halted cause = 1, `dbg_step_req` at 30 → `pipe_halt` = 0 only in cycle 31. With `retire` driven one cycle per issued instruction, `retire_cnt` grows by exactly 1. `step_done` pulses and `halted` = 1 at 35.
- **Simultaneous events:**
  - `halt_instr` and `dbg_halt_req` together → cause = 2.
  - step and resume together in HALTED → STEP.
  - `halt_instr` during STEP → cause = 2, no `step_done`.
- **Reset mid-drain and wrap:**
  - reset asserted in the 2nd DRAIN cycle → BOOT, counters 0, cause 0.
  - with `CNT_W` = 4, 16 RUN cycles → `cycle_cnt` wraps 15 → 0.
